// File: rtl/pipe_hazard_ctrl.sv
// Decode/execute sequencer: register scoreboard with RAW/WAW stalls, branch squash and fetch redirect.
// Optional macro HAZARD_FWD_EN: only loads hold their scoreboard bit, other writers are covered by EX->ID forwarding.
module pipe_hazard_ctrl #(
    parameter int REG_SEL_W    = 5,
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 id_rs1_dv,
    input  logic [REG_SEL_W-1:0] id_rs1_addr,
    input  logic                 id_rs2_dv,
    input  logic [REG_SEL_W-1:0] id_rs2_addr,
    input  logic [REG_SEL_W-1:0] id_rd_addr,
    input  logic [6:0]           id_opcode,
    input  logic                 wb_dv,
    input  logic [REG_SEL_W-1:0] wb_addr,
    input  logic                 br_flush,
    input  logic [XLEN-1:0]      br_pc,
    output logic                 issue,
    output logic                 stall,
    output logic                 ex_bubble,
    output logic [XLEN-1:0]      fetch_pc,
    output logic                 fetch_new_pc,
    output logic                 fetch_noop,
    output logic [31:0]          stall_cnt
);
    localparam int NREG = 1 << REG_SEL_W;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IMMED = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [NREG-1:0]   sb_q, sb_d, sb_clr, sb_set, sb_p;
    logic [XLEN-1:0]   pc_q;
    logic              new_pc_q;
    logic              init_q;
    logic [31:0]       stall_cnt_q;
    logic              active, is_load, writes_rd, hold_bit, hazard;

    // Outputs stay quiet for the reset cycle and the one after it.
    assign active = !rst && !init_q;

    assign is_load   = (id_opcode == OP_LOAD);
    assign writes_rd = is_load || (id_opcode inside {OP_RTYPE, OP_IMMED, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});

`ifdef HAZARD_FWD_EN
    // Non-load results reach the next consumer through forwarding, so they never occupy the scoreboard.
    assign hold_bit = is_load;
`else
    assign hold_bit = writes_rd;
`endif

    always_comb begin
        sb_clr = '0;
        if (wb_dv) sb_clr[wb_addr] = 1'b1;
    end

    // Same-cycle writeback is bypassed by the regfile, so it never hazards.
    assign sb_p   = sb_q & ~sb_clr;
    assign hazard = (id_rs1_dv && sb_p[id_rs1_addr]) ||
                    (id_rs2_dv && sb_p[id_rs2_addr]) ||
                    (writes_rd && sb_p[id_rd_addr]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        issue      = 1'b0;
        stall      = 1'b0;
        ex_bubble  = 1'b0;
        fetch_noop = 1'b0;
        if (active) begin
            case (state_q)
                RUN, STALL: begin
                    state_d = RUN;
                    if (id_valid) begin
                        if (hazard) begin
                            stall     = 1'b1;
                            ex_bubble = 1'b1;
                            state_d   = STALL;
                        end else begin
                            issue = 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    fetch_noop = 1'b1;
                    ex_bubble  = 1'b1;
                    if (cnt_q == 3'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                default: state_d = RUN;
            endcase
            // A redirect squashes whatever decode holds and restarts the flush window.
            if (br_flush) begin
                issue     = 1'b0;
                stall     = 1'b0;
                ex_bubble = 1'b1;
                state_d   = FLUSH;
                cnt_d     = 3'(FLUSH_CYCLES - 1);
            end
        end
    end

    always_comb begin
        sb_set = '0;
        if (issue && hold_bit && id_rd_addr != '0) sb_set[id_rd_addr] = 1'b1;
    end

    // Set wins over a same-cycle clear: the newly issued writer owns the register.
    assign sb_d = sb_p | sb_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            sb_q        <= '0;
            pc_q        <= '0;
            new_pc_q    <= 1'b0;
            init_q      <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sb_q     <= sb_d;
            init_q   <= 1'b0;
            new_pc_q <= active && br_flush;
            if (active && br_flush) pc_q <= br_pc;
            if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_pc     = pc_q;
    assign fetch_new_pc = new_pc_q;
    assign stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, RAW/WAW stalls, x0, flush/redirect, wb collision, forwarding option.
module tb_pipe_hazard_ctrl;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IMMED = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_dv, id_rs2_dv;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [6:0]  id_opcode;
    logic        wb_dv;
    logic [4:0]  wb_addr;
    logic        br_flush;
    logic [31:0] br_pc;
    logic        issue, stall, ex_bubble, fetch_new_pc, fetch_noop;
    logic [31:0] fetch_pc, stall_cnt;

    int nchk = 0;
    int nerr = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_dv(id_rs1_dv), .id_rs1_addr(id_rs1_addr),
        .id_rs2_dv(id_rs2_dv), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_opcode(id_opcode), .wb_dv(wb_dv), .wb_addr(wb_addr),
        .br_flush(br_flush), .br_pc(br_pc),
        .issue(issue), .stall(stall), .ex_bubble(ex_bubble),
        .fetch_pc(fetch_pc), .fetch_new_pc(fetch_new_pc), .fetch_noop(fetch_noop),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then leave time for new inputs to settle before checks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic inst(input logic [6:0] op, input logic [4:0] rd,
                        input logic r1v, input logic [4:0] r1,
                        input logic r2v, input logic [4:0] r2);
        id_valid = 1'b1; id_opcode = op; id_rd_addr = rd;
        id_rs1_dv = r1v; id_rs1_addr = r1; id_rs2_dv = r2v; id_rs2_addr = r2;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_opcode = 7'd0; id_rd_addr = 5'd0;
        id_rs1_dv = 1'b0; id_rs1_addr = 5'd0; id_rs2_dv = 1'b0; id_rs2_addr = 5'd0;
    endtask

    task automatic wb(input logic v, input logic [4:0] a);
        wb_dv = v; wb_addr = a;
    endtask

    initial begin
        rst = 1'b1; br_flush = 1'b0; br_pc = '0;
        idle(); wb(1'b0, 5'd0);
        inst(OP_IMMED, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);

        // T1: reset cycles and first issue
        tick(); settle();
        chk("rst_issue", {31'd0, issue}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bubble", {31'd0, ex_bubble}, 32'd0);
        chk("rst_newpc", {31'd0, fetch_new_pc}, 32'd0);
        chk("rst_noop", {31'd0, fetch_noop}, 32'd0);
        chk("rst_pc", fetch_pc, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        tick(); rst = 1'b0; settle();
        chk("post_rst_issue", {31'd0, issue}, 32'd0);
        tick(); settle();
        chk("t1_issue", {31'd0, issue}, 32'd1);
        tick(); idle(); wb(1'b1, 5'd9); settle();
        chk("t1_idle", {31'd0, issue | stall}, 32'd0);

        // T2: load x5 then add x6,x5,x1
        tick(); wb(1'b0, 5'd0); inst(OP_LOAD, 5'd5, 1'b1, 5'd2, 1'b0, 5'd0); settle();
        chk("t2_ld_issue", {31'd0, issue}, 32'd1);
        tick(); inst(OP_RTYPE, 5'd6, 1'b1, 5'd5, 1'b1, 5'd1); settle();
        chk("t2_stall1", {31'd0, stall}, 32'd1);
        chk("t2_bubble1", {31'd0, ex_bubble}, 32'd1);
        chk("t2_noissue", {31'd0, issue}, 32'd0);
        tick(); settle();
        chk("t2_stall2", {31'd0, stall}, 32'd1);
        tick(); wb(1'b1, 5'd5); settle();
        chk("t2_wb_issue", {31'd0, issue}, 32'd1);
        chk("t2_wb_nostall", {31'd0, stall}, 32'd0);
        chk("t2_cnt", stall_cnt, 32'd2);
        tick(); idle(); wb(1'b1, 5'd6); settle();
        chk("t2_cnt_hold", stall_cnt, 32'd2);

        // T3: x0 never hazards
        tick(); wb(1'b0, 5'd0); inst(OP_IMMED, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0); settle();
        chk("t3_a", {31'd0, issue}, 32'd1);
        tick(); inst(OP_LOAD, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0); settle();
        chk("t3_b", {31'd0, issue}, 32'd1);
        tick(); inst(OP_RTYPE, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0); settle();
        chk("t3_c", {31'd0, issue}, 32'd1);
        chk("t3_c_stall", {31'd0, stall}, 32'd0);

        // T4: flush while stalled
        tick(); inst(OP_LOAD, 5'd10, 1'b1, 5'd2, 1'b0, 5'd0); settle();
        chk("t4_ld", {31'd0, issue}, 32'd1);
        tick(); inst(OP_RTYPE, 5'd11, 1'b1, 5'd10, 1'b0, 5'd0); settle();
        chk("t4_stall", {31'd0, stall}, 32'd1);
        tick(); br_flush = 1'b1; br_pc = 32'h100; settle();
        chk("t4_br_stall", {31'd0, stall}, 32'd0);
        chk("t4_br_issue", {31'd0, issue}, 32'd0);
        chk("t4_br_bubble", {31'd0, ex_bubble}, 32'd1);
        tick(); br_flush = 1'b0; br_pc = 32'h0; settle();
        chk("t4_newpc", {31'd0, fetch_new_pc}, 32'd1);
        chk("t4_pc", fetch_pc, 32'h100);
        chk("t4_noop1", {31'd0, fetch_noop}, 32'd1);
        chk("t4_f1_issue", {31'd0, issue}, 32'd0);
        tick(); settle();
        chk("t4_newpc_off", {31'd0, fetch_new_pc}, 32'd0);
        chk("t4_noop2", {31'd0, fetch_noop}, 32'd1);
        chk("t4_f2_issue", {31'd0, issue | stall}, 32'd0);
        tick(); idle(); settle();
        chk("t4_run", {31'd0, fetch_noop}, 32'd0);
        chk("t4_pc_hold", fetch_pc, 32'h100);
        chk("t4_cnt", stall_cnt, 32'd3);
        // x10 survives the flush; squashed x11 writer left nothing behind
        tick(); inst(OP_RTYPE, 5'd12, 1'b1, 5'd10, 1'b0, 5'd0); settle();
        chk("t4_survive", {31'd0, stall}, 32'd1);
        tick(); wb(1'b1, 5'd10); settle();
        chk("t4_survive_wb", {31'd0, issue}, 32'd1);
        tick(); wb(1'b0, 5'd0); inst(OP_RTYPE, 5'd13, 1'b1, 5'd11, 1'b0, 5'd0); settle();
        chk("t4_squash_rd", {31'd0, issue}, 32'd1);

        // T5: issue/writeback collision on x7
        tick(); inst(OP_LOAD, 5'd7, 1'b1, 5'd2, 1'b0, 5'd0); settle();
        chk("t5_ld1", {31'd0, issue}, 32'd1);
        tick(); inst(OP_LOAD, 5'd7, 1'b1, 5'd2, 1'b0, 5'd0); wb(1'b1, 5'd7); settle();
        chk("t5_ld2", {31'd0, issue}, 32'd1);
        tick(); wb(1'b0, 5'd0); inst(OP_RTYPE, 5'd14, 1'b1, 5'd7, 1'b0, 5'd0); settle();
        chk("t5_reader_stall", {31'd0, stall}, 32'd1);
        tick(); wb(1'b1, 5'd7); settle();
        chk("t5_reader_issue", {31'd0, issue}, 32'd1);

        // T6: ALU-use vs load-use
        tick(); wb(1'b0, 5'd0); inst(OP_IMMED, 5'd3, 1'b1, 5'd2, 1'b0, 5'd0); settle();
        chk("t6_addi", {31'd0, issue}, 32'd1);
        tick(); inst(OP_RTYPE, 5'd4, 1'b1, 5'd3, 1'b1, 5'd3); settle();
`ifdef HAZARD_FWD_EN
        chk("t6_alu_use", {31'd0, stall}, 32'd0);
`else
        chk("t6_alu_use", {31'd0, stall}, 32'd1);
        tick(); wb(1'b1, 5'd3); settle();
        chk("t6_alu_use_wb", {31'd0, issue}, 32'd1);
`endif
        tick(); wb(1'b0, 5'd0); inst(OP_LOAD, 5'd3, 1'b1, 5'd2, 1'b0, 5'd0); settle();
        chk("t6_ld", {31'd0, issue}, 32'd1);
        tick(); inst(OP_RTYPE, 5'd15, 1'b1, 5'd3, 1'b1, 5'd3); settle();
        chk("t6_load_use", {31'd0, stall}, 32'd1);
        tick(); wb(1'b1, 5'd3); settle();
        chk("t6_load_use_wb", {31'd0, issue}, 32'd1);
`ifdef HAZARD_FWD_EN
        chk("t6_cnt", stall_cnt, 32'd6);
`else
        chk("t6_cnt", stall_cnt, 32'd7);
`endif

        // Back-to-back redirects restart the flush window
        tick(); wb(1'b0, 5'd0); idle(); br_flush = 1'b1; br_pc = 32'h200; settle();
        chk("rb_bubble", {31'd0, ex_bubble}, 32'd1);
        tick(); br_pc = 32'h300; settle();
        chk("rb_newpc1", {31'd0, fetch_new_pc}, 32'd1);
        chk("rb_pc1", fetch_pc, 32'h200);
        tick(); br_flush = 1'b0; br_pc = 32'h0; settle();
        chk("rb_newpc2", {31'd0, fetch_new_pc}, 32'd1);
        chk("rb_pc2", fetch_pc, 32'h300);
        chk("rb_noop2", {31'd0, fetch_noop}, 32'd1);
        tick(); settle();
        chk("rb_noop3", {31'd0, fetch_noop}, 32'd1);
        chk("rb_newpc3", {31'd0, fetch_new_pc}, 32'd0);
        tick(); settle();
        chk("rb_run", {31'd0, fetch_noop}, 32'd0);

        // T7: reset in the middle of a stall
        tick(); inst(OP_LOAD, 5'd20, 1'b1, 5'd2, 1'b0, 5'd0); settle();
        chk("t7_ld", {31'd0, issue}, 32'd1);
        tick(); inst(OP_RTYPE, 5'd21, 1'b1, 5'd20, 1'b0, 5'd0); settle();
        chk("t7_stall", {31'd0, stall}, 32'd1);
        tick(); rst = 1'b1; settle();
        chk("t7_rst_stall", {31'd0, stall | issue}, 32'd0);
        tick(); rst = 1'b0; settle();
        chk("t7_post_rst", {31'd0, stall | issue}, 32'd0);
        chk("t7_cnt_clr", stall_cnt, 32'd0);
        tick(); settle();
        chk("t7_issue", {31'd0, issue}, 32'd1);
        chk("t7_nostall", {31'd0, stall}, 32'd0);

        tick(); idle();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
